// File: rtl/reaction_timer_ctrl.sv
// reaction_timer_ctrl
//   Runs one reaction-time trial. When start is accepted it samples the LFSR nibble and
//   turns it into a random wait. After the wait it lights the stimulus LED and measures the
//   player's response in whole milliseconds. A stop during the wait is a false start. No
//   stop before TIMEOUT_MS is a timeout.
//
//   state  | meaning
//   -------+---------------------------------------------------------------
//   IDLE   | after reset, waiting for start
//   WAIT   | random delay is running, LED off, stop means a false start
//   ARMED  | LED on, counting the reaction time in ms
//   RESULT | trial finished, results held until the next start
//
// Ports
//   clk          system clock
//   reset_n      asynchronous active-low reset
//   start        one-cycle start pulse (debounced)
//   stop         one-cycle response pulse (debounced)
//   rnd[3:0]     LFSR nibble, sampled only when start is accepted
//   led          stimulus lamp, high only in ARMED
//   busy         high in WAIT or ARMED
//   done         one-cycle pulse on entry to RESULT
//   time_ms      reaction time of the last trial
//   false_start  last trial ended by stop during WAIT
//   timeout      last trial reached TIMEOUT_MS
//   best_ms      best valid time since reset (only when BEST_TIME_EN is defined)
//
// Build option: define BEST_TIME_EN to add the best_ms port and register.

module reaction_timer_ctrl #(
  parameter int CLKS_PER_MS  = 50000,
  parameter int MIN_DELAY_MS = 1000,
  parameter int STEP_MS      = 250,
  parameter int TIMEOUT_MS   = 9999,
  parameter int TW           = 14
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  input  logic          stop,
  input  logic [3:0]    rnd,
  output logic          led,
  output logic          busy,
  output logic          done,
  output logic [TW-1:0] time_ms,
  output logic          false_start,
  output logic          timeout
`ifdef BEST_TIME_EN
  ,
  output logic [TW-1:0] best_ms
`endif
);

  localparam int PW = $clog2(CLKS_PER_MS);
  localparam logic [PW-1:0] PRESC_LAST   = PW'(CLKS_PER_MS - 1);
  localparam logic [15:0]   TIMEOUT_LAST = 16'(TIMEOUT_MS - 1);
  localparam logic [TW-1:0] TIMEOUT_VAL  = TW'(TIMEOUT_MS);
  localparam logic [15:0]   MIN_D        = 16'(MIN_DELAY_MS);
  localparam logic [15:0]   STEP_D       = 16'(STEP_MS);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_ARMED  = 2'd2,
    S_RESULT = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [PW-1:0]   r_presc;
  logic [15:0]     r_ms_cnt;
  logic [15:0]     r_delay_ms;
  logic [TW-1:0]   r_time_ms;
  logic            r_false_start;
  logic            r_timeout;
  logic            r_done;

  logic            w_ms_tick;
  logic            w_state_chg;
  logic            w_accept_start;
  logic            w_false_stop;
  logic            w_armed_stop;
  logic            w_timeout_hit;
  logic [15:0]     w_delay_calc;

  assign w_ms_tick    = (r_presc == PRESC_LAST);
  assign w_state_chg  = (w_state_nxt != r_state);
  assign w_delay_calc = MIN_D + ({12'd0, rnd} * STEP_D);

  // Next state. stop has priority over a coincident ms_tick; start has priority over
  // stop in IDLE/RESULT.
  always_comb begin
    w_state_nxt    = r_state;
    w_accept_start = 1'b0;
    w_false_stop   = 1'b0;
    w_armed_stop   = 1'b0;
    w_timeout_hit  = 1'b0;
    case (r_state)
      S_IDLE, S_RESULT: begin
        if (start) begin
          w_state_nxt    = S_WAIT;
          w_accept_start = 1'b1;
        end
      end
      S_WAIT: begin
        if (stop) begin
          w_state_nxt  = S_RESULT;
          w_false_stop = 1'b1;
        end else if (w_ms_tick && (r_ms_cnt == r_delay_ms - 16'd1)) begin
          w_state_nxt = S_ARMED;
        end
      end
      S_ARMED: begin
        if (stop) begin
          w_state_nxt  = S_RESULT;
          w_armed_stop = 1'b1;
        end else if (w_ms_tick && (r_ms_cnt == TIMEOUT_LAST)) begin
          w_state_nxt   = S_RESULT;
          w_timeout_hit = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Prescaler and ms counter restart on every state change so each state measures
  // time from its own entry.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_presc  <= '0;
      r_ms_cnt <= '0;
    end else if (w_state_chg) begin
      r_presc  <= '0;
      r_ms_cnt <= '0;
    end else if (w_ms_tick) begin
      r_presc  <= '0;
      r_ms_cnt <= r_ms_cnt + 16'd1;
    end else begin
      r_presc  <= r_presc + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_delay_ms    <= '0;
      r_time_ms     <= '0;
      r_false_start <= 1'b0;
      r_timeout     <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_done <= (w_state_nxt == S_RESULT) && (r_state != S_RESULT);
      if (w_accept_start) begin
        r_delay_ms    <= w_delay_calc;
        r_time_ms     <= '0;
        r_false_start <= 1'b0;
        r_timeout     <= 1'b0;
      end
      if (w_false_stop) begin
        r_false_start <= 1'b1;
        r_time_ms     <= '0;
      end
      // ms_cnt never passes TIMEOUT_MS-1 in ARMED, so it fits in TW bits.
      if (w_armed_stop) r_time_ms <= TW'(r_ms_cnt);
      if (w_timeout_hit) begin
        r_timeout <= 1'b1;
        r_time_ms <= TIMEOUT_VAL;
      end
    end
  end

`ifdef BEST_TIME_EN
  logic [TW-1:0] r_best_ms;

  // Only stop-ended ARMED exits count; false starts and timeouts leave it alone.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      r_best_ms <= '1;
    else if (w_armed_stop && (TW'(r_ms_cnt) < r_best_ms))
      r_best_ms <= TW'(r_ms_cnt);
  end

  assign best_ms = r_best_ms;
`else
  // No best-time tracking in this build.
`endif

  // led/busy decode straight from the state so reset drops them without a clock.
  assign led         = (r_state == S_ARMED);
  assign busy        = (r_state == S_WAIT) || (r_state == S_ARMED);
  assign done        = r_done;
  assign time_ms     = r_time_ms;
  assign false_start = r_false_start;
  assign timeout     = r_timeout;

endmodule

// File: tb/tb_reaction_timer_ctrl.sv
module tb_reaction_timer_ctrl;

  localparam int TW = 14;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic [3:0]    rnd = 4'd0;
  logic          led;
  logic          busy;
  logic          done;
  logic [TW-1:0] time_ms;
  logic          false_start;
  logic          timeout;
`ifdef BEST_TIME_EN
  logic [TW-1:0] best_ms;
`endif

  int vectors = 0;
  int miscompares = 0;

  reaction_timer_ctrl #(
    .CLKS_PER_MS (4),
    .MIN_DELAY_MS(2),
    .STEP_MS     (1),
    .TIMEOUT_MS  (20),
    .TW          (TW)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .stop       (stop),
    .rnd        (rnd),
    .led        (led),
    .busy       (busy),
    .done       (done),
    .time_ms    (time_ms),
    .false_start(false_start),
    .timeout    (timeout)
`ifdef BEST_TIME_EN
    ,
    .best_ms    (best_ms)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Cycle c is the interval after clock edge c; start is driven in cycle 0.
  // Records LED rise/fall cycles and done pulses over cycles 1..n_cyc.
  task automatic run_trial(input logic [3:0] r, input int stop_at, input int restart_at,
                           input int n_cyc,
                           output int led_rise, output int led_fall,
                           output int done_at, output int done_n,
                           output logic busy1, output logic [TW-1:0] time1);
    led_rise = -1; led_fall = -1; done_at = -1; done_n = 0;
    busy1 = 1'b0; time1 = '1;
    start = 1'b1; rnd = r; stop = 1'b0;
    step();
    start = 1'b0;
    for (int c = 1; c <= n_cyc; c++) begin
      if (c == 1) begin busy1 = busy; time1 = time_ms; end
      if (led && led_rise < 0) led_rise = c;
      if (!led && led_rise >= 0 && led_fall < 0) led_fall = c;
      if (done) begin
        done_n++;
        if (done_at < 0) done_at = c;
      end
      stop  = (c == stop_at);
      start = (c == restart_at);
      rnd   = (c == restart_at) ? 4'hF : 4'($urandom_range(0, 15));
      step();
    end
    stop = 1'b0;
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      start = 1'($urandom_range(0, 1));
      stop  = 1'($urandom_range(0, 1));
      rnd   = 4'($urandom_range(0, 15));
      step();
      vectors++;
      if ({led, busy, done, false_start, timeout} !== 5'b0) begin
        $display("FAIL reset_flags: got %b expected 00000", {led, busy, done, false_start, timeout});
        miscompares++;
      end
      vectors++;
      if (time_ms !== '0) begin
        $display("FAIL reset_time: got %0d expected 0", time_ms);
        miscompares++;
      end
`ifdef BEST_TIME_EN
      vectors++;
      if (best_ms !== {TW{1'b1}}) begin
        $display("FAIL reset_best: got %0d expected %0d", best_ms, {TW{1'b1}});
        miscompares++;
      end
`endif
    end
    start = 1'b0; stop = 1'b0;
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_normal();
    int lr, lf, da, dn; logic b1; logic [TW-1:0] t1;
    // rnd=3 -> 5 ms wait; a second start in WAIT (rnd=15) must be ignored.
    run_trial(4'd3, 33, 10, 40, lr, lf, da, dn, b1, t1);
    vectors++;
    if (b1 !== 1'b1) begin $display("FAIL normal_busy1: got %b expected 1", b1); miscompares++; end
    vectors++;
    if (lr !== 21) begin $display("FAIL normal_led_rise: got %0d expected 21", lr); miscompares++; end
    vectors++;
    if (lf !== 34) begin $display("FAIL normal_led_fall: got %0d expected 34", lf); miscompares++; end
    vectors++;
    if (da !== 34 || dn !== 1) begin
      $display("FAIL normal_done: got cycle %0d count %0d expected cycle 34 count 1", da, dn);
      miscompares++;
    end
    vectors++;
    if (time_ms !== 14'd3) begin $display("FAIL normal_time: got %0d expected 3", time_ms); miscompares++; end
    vectors++;
    if ({false_start, timeout, busy} !== 3'b000) begin
      $display("FAIL normal_flags: got %b expected 000", {false_start, timeout, busy});
      miscompares++;
    end
  endtask

  task automatic test_false_start();
    int lr, lf, da, dn; logic b1; logic [TW-1:0] t1;
    run_trial(4'd0, 5, -1, 12, lr, lf, da, dn, b1, t1);
    vectors++;
    if (t1 !== '0) begin $display("FAIL fs_time_cleared: got %0d expected 0", t1); miscompares++; end
    vectors++;
    if (lr !== -1) begin $display("FAIL fs_led: got rise %0d expected none (-1)", lr); miscompares++; end
    vectors++;
    if (da !== 6 || dn !== 1) begin
      $display("FAIL fs_done: got cycle %0d count %0d expected cycle 6 count 1", da, dn);
      miscompares++;
    end
    vectors++;
    if ({false_start, timeout} !== 2'b10 || time_ms !== '0) begin
      $display("FAIL fs_result: got fs/to %b time %0d expected 10 time 0", {false_start, timeout}, time_ms);
      miscompares++;
    end
    // stop in RESULT is ignored
    stop = 1'b1; step(); stop = 1'b0; step();
    vectors++;
    if ({false_start, done, busy} !== 3'b100 || time_ms !== '0) begin
      $display("FAIL result_stop_ignored: got fs/done/busy %b time %0d expected 100 time 0",
               {false_start, done, busy}, time_ms);
      miscompares++;
    end
  endtask

  task automatic test_priority();
    int lr, lf, da, dn; logic b1; logic [TW-1:0] t1;
    // stop sampled on the very tick that would arm: false start wins.
    run_trial(4'd0, 8, -1, 14, lr, lf, da, dn, b1, t1);
    vectors++;
    if (false_start !== 1'b1 || lr !== -1 || da !== 9) begin
      $display("FAIL prio_wait: got fs %b led_rise %0d done %0d expected 1 -1 9", false_start, lr, da);
      miscompares++;
    end
    // stop sampled with the 2nd ms tick in ARMED: time is the pre-increment count 1.
    run_trial(4'd0, 16, -1, 20, lr, lf, da, dn, b1, t1);
    vectors++;
    if (time_ms !== 14'd1 || lr !== 9 || da !== 17 || false_start !== 1'b0) begin
      $display("FAIL prio_armed: got time %0d led %0d done %0d fs %b expected 1 9 17 0",
               time_ms, lr, da, false_start);
      miscompares++;
    end
  endtask

  task automatic test_timeout();
    int lr, lf, da, dn; logic b1; logic [TW-1:0] t1;
    run_trial(4'd0, -1, 50, 100, lr, lf, da, dn, b1, t1);
    vectors++;
    if (lr !== 9) begin $display("FAIL to_led_rise: got %0d expected 9", lr); miscompares++; end
    vectors++;
    if (lf !== 89) begin $display("FAIL to_led_fall: got %0d expected 89", lf); miscompares++; end
    vectors++;
    if (da !== 89 || dn !== 1) begin
      $display("FAIL to_done: got cycle %0d count %0d expected cycle 89 count 1", da, dn);
      miscompares++;
    end
    vectors++;
    if (timeout !== 1'b1 || time_ms !== 14'd20 || false_start !== 1'b0) begin
      $display("FAIL to_result: got to %b time %0d fs %b expected 1 20 0", timeout, time_ms, false_start);
      miscompares++;
    end
  endtask

  task automatic test_reset_mid();
    int lr, lf, da, dn; logic b1; logic [TW-1:0] t1;
    run_trial(4'd0, -1, -1, 10, lr, lf, da, dn, b1, t1);
    vectors++;
    if (led !== 1'b1) begin $display("FAIL mid_armed: got led %b expected 1", led); miscompares++; end
    reset_n = 1'b0;
    #2;
    vectors++;
    if ({led, busy, done, timeout} !== 4'b0000) begin
      $display("FAIL mid_async: got led/busy/done/to %b expected 0000", {led, busy, done, timeout});
      miscompares++;
    end
    step();
    reset_n = 1'b1;
    step();
    run_trial(4'd0, 12, -1, 16, lr, lf, da, dn, b1, t1);
    vectors++;
    if (lr !== 9 || da !== 13 || time_ms !== '0 || false_start !== 1'b0) begin
      $display("FAIL mid_rerun: got led %0d done %0d time %0d fs %b expected 9 13 0 0",
               lr, da, time_ms, false_start);
      miscompares++;
    end
  endtask

  task automatic test_back_to_back();
    int lr, lf, da, dn; logic b1; logic [TW-1:0] t1;
    run_trial(4'd0, 14, -1, 14, lr, lf, da, dn, b1, t1);
    vectors++;
    if (done !== 1'b1 || time_ms !== 14'd1) begin
      $display("FAIL b2b_first: got done %b time %0d expected 1 1", done, time_ms);
      miscompares++;
    end
    // start in the done cycle (RESULT) begins the next trial at once
    run_trial(4'd2, 26, -1, 30, lr, lf, da, dn, b1, t1);
    vectors++;
    if (b1 !== 1'b1 || t1 !== '0) begin
      $display("FAIL b2b_restart: got busy %b time %0d expected 1 0", b1, t1);
      miscompares++;
    end
    vectors++;
    if (lr !== 17 || da !== 27 || time_ms !== 14'd2) begin
      $display("FAIL b2b_second: got led %0d done %0d time %0d expected 17 27 2", lr, da, time_ms);
      miscompares++;
    end
  endtask

  task automatic test_start_stop_idle();
    reset_n = 1'b0; step(); reset_n = 1'b1; step();
    start = 1'b1; stop = 1'b1; rnd = 4'd0;
    step();
    start = 1'b0; stop = 1'b0;
    step();
    vectors++;
    if ({busy, led, false_start, done} !== 4'b1000) begin
      $display("FAIL idle_start_stop: got busy/led/fs/done %b expected 1000", {busy, led, false_start, done});
      miscompares++;
    end
    reset_n = 1'b0; step(); reset_n = 1'b1; step();
  endtask

`ifdef BEST_TIME_EN
  task automatic test_best();
    int lr, lf, da, dn; logic b1; logic [TW-1:0] t1;
    int tv[3] = '{7, 3, 5};
    int bexp[3] = '{7, 3, 3};
    reset_n = 1'b0; step(); reset_n = 1'b1; step();
    for (int k = 0; k < 3; k++) begin
      // ARMED from cycle 9; stop one cycle after ms_cnt reaches T
      run_trial(4'd0, 9 + 4 * tv[k] + 1, -1, 9 + 4 * tv[k] + 1, lr, lf, da, dn, b1, t1);
      vectors++;
      if (done !== 1'b1 || time_ms !== TW'(tv[k]) || best_ms !== TW'(bexp[k])) begin
        $display("FAIL best_%0d: got done %b time %0d best %0d expected 1 %0d %0d",
                 k, done, time_ms, best_ms, tv[k], bexp[k]);
        miscompares++;
      end
    end
    run_trial(4'd0, 3, -1, 3, lr, lf, da, dn, b1, t1);
    vectors++;
    if (done !== 1'b1 || false_start !== 1'b1 || best_ms !== 14'd3) begin
      $display("FAIL best_false_start: got done %b fs %b best %0d expected 1 1 3", done, false_start, best_ms);
      miscompares++;
    end
  endtask
`endif

  initial begin
    test_reset();
    test_normal();
    test_false_start();
    test_priority();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    test_start_stop_idle();
`ifdef BEST_TIME_EN
    test_best();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
